keyboard_ps2: RTL and testbench

KEYBOARD_PS2 -- requirements
Module: keyboard_ps2

---
 rtl/keyboard_ps2_pkg.sv | 42 ++++
 rtl/keyboard_ps2_to_hack.sv | 75 +++++++
 rtl/keyboard_ps2.sv | 174 +++++++++++++++++
 tb/tb_keyboard_ps2.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/keyboard_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   - ps2_state_t      : frame FSM state encoding
//   - DEFAULT_*        : default filter length and frame timeout
//   - KEY_*            : Hack key codes for the non-printable keys (128..152)
//   - SC_EXTEND/BREAK  : scancode prefix bytes
//   - odd_ones()       : odd-parity test over data byte + parity bit
package keyboard_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int DEFAULT_FILTER_LEN = 4;
    localparam int DEFAULT_TIMEOUT    = 50000;

    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;  // F1..F12 are 141..152

    localparam logic [7:0] SC_EXTEND = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;

    // True when the 9 bits (data + parity) carry an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/keyboard_ps2_to_hack.sv
// Combinational scancode (set 2) to Hack key-code translation.
// Ports:
//   extended : 1 when the code was preceded by the E0 prefix
//   code     : 8-bit scancode
//   hack     : 16-bit Hack key code, 0 when the key is not mapped
//   valid    : 1 when the key is mapped
module ps2_to_hack
    import keyboard_ps2_pkg::*;
(
    input  logic        extended,
    input  logic [7:0]  code,
    output logic [15:0] hack,
    output logic        valid
);

    always_comb begin
        // NOTE: default every output first so no path through the case can infer a latch.
        hack = '0;
        if (extended) begin
            case (code)
                8'h6B:   hack = KEY_LEFT;
                8'h75:   hack = KEY_UP;
                8'h74:   hack = KEY_RIGHT;
                8'h72:   hack = KEY_DOWN;
                8'h6C:   hack = KEY_HOME;
                8'h69:   hack = KEY_END;
                8'h7D:   hack = KEY_PGUP;
                8'h7A:   hack = KEY_PGDN;
                8'h70:   hack = KEY_INSERT;
                8'h71:   hack = KEY_DELETE;
                default: hack = '0;
            endcase
        end else begin
            case (code)
                // letters A..Z
                8'h1C: hack = 16'd65;  8'h32: hack = 16'd66;  8'h21: hack = 16'd67;
                8'h23: hack = 16'd68;  8'h24: hack = 16'd69;  8'h2B: hack = 16'd70;
                8'h34: hack = 16'd71;  8'h33: hack = 16'd72;  8'h43: hack = 16'd73;
                8'h3B: hack = 16'd74;  8'h42: hack = 16'd75;  8'h4B: hack = 16'd76;
                8'h3A: hack = 16'd77;  8'h31: hack = 16'd78;  8'h44: hack = 16'd79;
                8'h4D: hack = 16'd80;  8'h15: hack = 16'd81;  8'h2D: hack = 16'd82;
                8'h1B: hack = 16'd83;  8'h2C: hack = 16'd84;  8'h3C: hack = 16'd85;
                8'h2A: hack = 16'd86;  8'h1D: hack = 16'd87;  8'h22: hack = 16'd88;
                8'h35: hack = 16'd89;  8'h1A: hack = 16'd90;
                // digits 0..9
                8'h45: hack = 16'd48;  8'h16: hack = 16'd49;  8'h1E: hack = 16'd50;
                8'h26: hack = 16'd51;  8'h25: hack = 16'd52;  8'h2E: hack = 16'd53;
                8'h36: hack = 16'd54;  8'h3D: hack = 16'd55;  8'h3E: hack = 16'd56;
                8'h46: hack = 16'd57;
                // control keys
                8'h29: hack = 16'd32;
                8'h5A: hack = KEY_NEWLINE;
                8'h66: hack = KEY_BACKSPACE;
                8'h76: hack = KEY_ESC;
                // function keys F1..F12
                8'h05: hack = KEY_F1;
                8'h06: hack = KEY_F1 + 16'd1;
                8'h04: hack = KEY_F1 + 16'd2;
                8'h0C: hack = KEY_F1 + 16'd3;
                8'h03: hack = KEY_F1 + 16'd4;
                8'h0B: hack = KEY_F1 + 16'd5;
                8'h83: hack = KEY_F1 + 16'd6;
                8'h0A: hack = KEY_F1 + 16'd7;
                8'h01: hack = KEY_F1 + 16'd8;
                8'h09: hack = KEY_F1 + 16'd9;
                8'h78: hack = KEY_F1 + 16'd10;
                8'h07: hack = KEY_F1 + 16'd11;
                default: hack = '0;
            endcase
        end
        // No mapped key translates to 0, so a zero result means "unmapped".
        valid = (hack != '0);
    end

endmodule

// File: rtl/keyboard_ps2.sv
// PS/2 keyboard receiver producing the Hack keyboard register value.
// Ports:
//   clk       : master clock, all state on its rising edge
//   reset     : synchronous active-high reset
//   ps2_clk   : asynchronous PS/2 device clock
//   ps2_data  : asynchronous PS/2 device data
//   kbd_out   : Hack code of the currently held key, 0 when none
//   frame_err : one-cycle pulse when a frame is discarded (bad parity/stop, timeout)
module keyboard_ps2
    import keyboard_ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_out,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    // ---------------------------------------------------------------
    // Two-flop synchronizers; the bus idles high.
    // ---------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] data_sync;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    wire ps2_clk_s  = clk_sync[1];
    wire ps2_data_s = data_sync[1];

    // ---------------------------------------------------------------
    // Glitch filter: the level flips only on the FILTER_LEN-th
    // consecutive sample that disagrees with it. fall is a registered
    // one-cycle strobe for each accepted 1->0 transition.
    // ---------------------------------------------------------------
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall       <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (ps2_clk_s != filt_level) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_level <= ps2_clk_s;
                    filt_cnt   <= '0;
                    fall       <= filt_level;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM, prefix flags and held-key tracking
    // ---------------------------------------------------------------
    ps2_state_t    state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic          ext_flag;
    logic          brk_flag;
    logic [TW-1:0] to_cnt;
    logic [8:0]    held_key;    // {extended, scancode} of the key in kbd_out

    logic [15:0]   xlate_code;
    logic          xlate_valid;

    ps2_to_hack u_xlate (
        .extended (ext_flag),
        .code     (shift_reg),
        .hack     (xlate_code),
        .valid    (xlate_valid)
    );

    // Evaluated in STOP: ps2_data_s is the stop bit at that point.
    wire frame_ok = odd_ones({shift_reg, parity_bit}) && ps2_data_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            to_cnt     <= '0;
            held_key   <= '0;
            kbd_out    <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall && !ps2_data_s) begin
                    state     <= DATA;
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        shift_reg <= {ps2_data_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= ps2_data_s;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                            ext_flag  <= 1'b0;
                            brk_flag  <= 1'b0;
                        end else if (shift_reg == SC_EXTEND) begin
                            ext_flag <= 1'b1;
                        end else if (shift_reg == SC_BREAK) begin
                            brk_flag <= 1'b1;
                        end else begin
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                            if (brk_flag) begin
                                // Only releasing the held key clears the output.
                                if (held_key == {ext_flag, shift_reg}) begin
                                    kbd_out  <= '0;
                                    held_key <= '0;
                                end
                            end else if (xlate_valid) begin
                                kbd_out  <= xlate_code;
                                held_key <= {ext_flag, shift_reg};
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (to_cnt == TO_LAST) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_ps2.sv
// Directed testbench for keyboard_ps2: drives PS/2 frames bit by bit and
// compares kbd_out / frame_err activity against hand-computed values.
module tb_keyboard_ps2;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 300;
    localparam int HALF_BIT   = 20;   // clk cycles per ps2_clk phase

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] kbd_out;
    logic        frame_err;

    int n_checks = 0;
    int n_fails  = 0;
    int err_count = 0;
    logic [15:0] stop_pre, stop_post;

    keyboard_ps2 #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbd_out   (kbd_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Each cycle frame_err is high counts once, so a stretched pulse over-counts.
    always @(posedge clk) if (frame_err === 1'b1) err_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF_BIT);
        ps2_clk = 1'b0;
        wait_cyc(HALF_BIT);
        ps2_clk = 1'b1;
    endtask

    // Full frame with explicit parity and stop; captures kbd_out just
    // before and just after the expected update following the stop edge.
    task automatic send_raw(input logic [7:0] b, input logic par, input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        ps2_data = stp;
        wait_cyc(HALF_BIT);
        ps2_clk = 1'b0;
        // 2 sync + FILTER_LEN filter samples -> fall strobe after 6 edges,
        // kbd_out registered on the 7th.
        wait_cyc(2 + FILTER_LEN);
        stop_pre = kbd_out;
        wait_cyc(1);
        stop_post = kbd_out;
        wait_cyc(HALF_BIT - 3 - FILTER_LEN);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(HALF_BIT);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, ~^b, 1'b1);
    endtask

    initial begin
        int e0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        check("reset_kbd_out", kbd_out, 0);
        check("reset_frame_err", frame_err, 0);
        reset = 1'b0;
        wait_cyc(5);

        // Basic make/break of A
        send_byte(8'h1C);
        check("A_before_update", stop_pre, 0);
        check("A_after_update", stop_post, 65);
        send_byte(8'hF0); send_byte(8'h1C);
        check("A_break", kbd_out, 0);

        // Extended left arrow vs. unmapped keypad 4
        send_byte(8'hE0); send_byte(8'h6B);
        check("ext_left", kbd_out, 130);
        send_byte(8'h6B);
        check("kp4_make_unmapped", kbd_out, 130);
        send_byte(8'hF0); send_byte(8'h6B);
        check("kp4_break_ignored", kbd_out, 130);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check("ext_left_break", kbd_out, 0);
        check("no_err_so_far", err_count, 0);

        // Parity error (0x1C has three ones, so good parity is 0)
        send_raw(8'h1C, 1'b1, 1'b1);
        check("parity_err_pulse", err_count, 1);
        check("parity_err_kbd", kbd_out, 0);
        // Bad stop bit, also flag clearing: E0 then bad frame then 6B is plain keypad 4
        send_byte(8'hE0);
        send_raw(8'h6B, ~^8'h6B, 1'b0);
        check("stop_err_pulse", err_count, 2);
        send_byte(8'h6B);
        check("flags_cleared_by_err", kbd_out, 0);

        // Held A, then B replaces it; releasing A leaves B
        send_byte(8'h1C);
        check("hold_A", kbd_out, 65);
        send_byte(8'h32);
        check("B_replaces", kbd_out, 66);
        send_byte(8'hF0); send_byte(8'h1C);
        check("release_A_keeps_B", kbd_out, 66);
        send_byte(8'h32);
        check("typematic_B", kbd_out, 66);
        send_byte(8'hF0); send_byte(8'h32);
        check("release_B", kbd_out, 0);

        // Timeout after start + 4 data bits
        e0 = err_count;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT + 40);
        check("timeout_err", err_count - e0, 1);
        send_byte(8'h29);
        check("space_after_timeout", kbd_out, 32);
        check("no_extra_err", err_count - e0, 1);
        send_byte(8'hF0); send_byte(8'h29);

        // Short ps2_clk glitch with data low must not start a frame
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(10);
        ps2_data = 1'b1;
        wait_cyc(5);
        send_byte(8'h16);
        check("glitch_ignored_digit1", kbd_out, 49);
        check("glitch_no_err", err_count - e0, 1);
        send_byte(8'hF0); send_byte(8'h16);

        // Assorted table entries
        send_byte(8'h5A);
        check("enter", kbd_out, 128);
        send_byte(8'h07);
        check("f12", kbd_out, 152);
        send_byte(8'h76);
        check("esc", kbd_out, 140);
        send_byte(8'hE0); send_byte(8'h7D);
        check("pgup", kbd_out, 136);
        send_byte(8'hE0); send_byte(8'h1C);
        check("ext_letter_unmapped", kbd_out, 136);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7D);
        check("pgup_break", kbd_out, 0);

        // Reset mid-frame while a key is held
        send_byte(8'h1C);
        check("pre_reset_hold", kbd_out, 65);
        e0 = err_count;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        reset = 1'b1;
        wait_cyc(3);
        check("reset_mid_kbd", kbd_out, 0);
        reset = 1'b0;
        wait_cyc(TIMEOUT + 40);
        check("reset_mid_no_err", err_count - e0, 0);
        send_byte(8'h1C);
        check("after_reset_frame", kbd_out, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
